// File: rtl/holy_clint_if.sv
// holy_clint_if: AXI-Lite bus bundle between the core's uncached data path and the CLINT
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/holy_clint.sv
// holy_clint: AXI-Lite core-local interruptor with mtime, mtimecmp and msip
module holy_clint #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF
) (
    input  logic      clk,
    input  logic      rst,
    axi_lite_if.slave axi_lite,
    output logic      timer_irq,
    output logic      soft_irq
);
    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    localparam logic [13:0] A_MSIP = 14'h0000;
    localparam logic [13:0] A_CMPL = 14'h1000;
    localparam logic [13:0] A_CMPH = 14'h1001;
    localparam logic [13:0] A_TIML = 14'h2FFE;
    localparam logic [13:0] A_TIMH = 14'h2FFF;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic mapped(input logic [13:0] idx);
        return idx == A_MSIP || idx == A_CMPL || idx == A_CMPH || idx == A_TIML || idx == A_TIMH;
    endfunction

    w_state_e      w_state_q, w_state_d;
    r_state_e      r_state_q, r_state_d;
    logic          aw_q, aw_d, w_q, w_d;
    logic [13:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d, cmp_q, cmp_d;
    logic          msip_q, msip_d;
    logic          timer_irq_q, soft_irq_q;
    logic          aw_hs, w_hs, do_wr, tick;
    logic [13:0]   wr_idx, rd_idx;
    logic [31:0]   wr_data, rd_val;
    logic [3:0]    wr_strb;
    logic          unused_addr;

    assign unused_addr = ^{axi_lite.awaddr[31:16], axi_lite.awaddr[1:0], axi_lite.araddr[31:16], axi_lite.araddr[1:0]};
    assign timer_irq = timer_irq_q;
    assign soft_irq  = soft_irq_q;

    // Write channel: independent AW/W capture, apply once both are held, then respond
    always_comb begin
        axi_lite.awready = w_state_q == W_IDLE && !aw_q;
        axi_lite.wready  = w_state_q == W_IDLE && !w_q;
        axi_lite.bvalid  = w_state_q == W_RESP;
        axi_lite.bresp   = bresp_q;
        aw_hs   = axi_lite.awvalid && w_state_q == W_IDLE && !aw_q;
        w_hs    = axi_lite.wvalid && w_state_q == W_IDLE && !w_q;
        wr_idx  = aw_q ? waddr_q : axi_lite.awaddr[15:2] & ADDR_MASK[15:2];
        wr_data = w_q ? wdata_q : axi_lite.wdata;
        wr_strb = w_q ? wstrb_q : axi_lite.wstrb;
        do_wr   = w_state_q == W_IDLE && (aw_q || aw_hs) && (w_q || w_hs);
        w_state_d = w_state_q;
        aw_d    = aw_q || aw_hs;
        w_d     = w_q || w_hs;
        waddr_d = aw_hs ? wr_idx : waddr_q;
        wdata_d = w_hs ? axi_lite.wdata : wdata_q;
        wstrb_d = w_hs ? axi_lite.wstrb : wstrb_q;
        bresp_d = bresp_q;
        if (do_wr) begin
            w_state_d = W_RESP;
            bresp_d   = mapped(wr_idx) ? 2'b00 : 2'b10;
        end else if (w_state_q == W_RESP && axi_lite.bready) begin
            w_state_d = W_IDLE;
            aw_d      = 1'b0;
            w_d       = 1'b0;
        end
    end

    // Read channel: snapshot register contents at the AR edge and hold until rready
    always_comb begin
        rd_idx = axi_lite.araddr[15:2] & ADDR_MASK[15:2];
        rd_val = rd_idx == A_MSIP ? {31'b0, msip_q} :
                 rd_idx == A_CMPL ? cmp_q[31:0] :
                 rd_idx == A_CMPH ? cmp_q[63:32] :
                 rd_idx == A_TIML ? mtime_q[31:0] :
                 rd_idx == A_TIMH ? mtime_q[63:32] : 32'h0;
        axi_lite.arready = r_state_q == R_IDLE;
        axi_lite.rvalid  = r_state_q == R_DATA;
        axi_lite.rdata   = rdata_q;
        axi_lite.rresp   = rresp_q;
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (r_state_q == R_IDLE && axi_lite.arvalid) begin
            r_state_d = R_DATA;
            rdata_d   = rd_val;
            rresp_d   = mapped(rd_idx) ? 2'b00 : 2'b10;
        end else if (r_state_q == R_DATA && axi_lite.rready) begin
            r_state_d = R_IDLE;
        end
    end

    // Timer and register next state; an mtime write overrides that cycle's increment
    always_comb begin
        tick    = presc_q == P_LAST;
        presc_d = tick ? '0 : presc_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        msip_d  = msip_q;
        if (do_wr) begin
            if (wr_idx == A_MSIP && wr_strb[0]) msip_d = wr_data[0];
            if (wr_idx == A_CMPL) cmp_d[31:0] = merge(cmp_q[31:0], wr_data, wr_strb);
            if (wr_idx == A_CMPH) cmp_d[63:32] = merge(cmp_q[63:32], wr_data, wr_strb);
            if (wr_idx == A_TIML) mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strb)};
            if (wr_idx == A_TIMH) mtime_d = {merge(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
        end
    end

    // State registers; reset discards any half-captured write and drops responses
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            aw_q        <= 1'b0;
            w_q         <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bresp_q     <= 2'b00;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            presc_q     <= '0;
            mtime_q     <= '0;
            cmp_q       <= '1;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            aw_q        <= aw_d;
            w_q         <= w_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bresp_q     <= bresp_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            cmp_q       <= cmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= mtime_q >= cmp_q;
            soft_irq_q  <= msip_q;
        end
    end
endmodule

// File: tb/tb_holy_clint.sv
// tb_holy_clint: scoreboard bench for the CLINT register map, timer and interrupts
module tb_holy_clint;
    typedef struct packed {logic [31:0] d; logic [1:0] r;} rexp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timer_irq, soft_irq;
    int total = 0;
    int bad = 0;
    logic [63:0] cyc = '0;
    logic [63:0] m_off, m_cmp;
    logic m_msip;
    logic irq_at [0:1023];
    logic soft_at [0:1023];
    rexp_t rq[$];
    logic [1:0] bq[$];

    axi_lite_if bus();
    holy_clint #(.TICK_DIV(1), .ADDR_MASK(32'h0000_FFFF)) dut (
        .clk(clk), .rst(rst), .axi_lite(bus), .timer_irq(timer_irq), .soft_irq(soft_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 64'd0 : cyc + 64'd1;
    always @(negedge clk) begin
        irq_at[cyc[9:0]]  <= timer_irq;
        soft_at[cyc[9:0]] <= soft_irq;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        return {s[3] ? n[31:24] : o[31:24], s[2] ? n[23:16] : o[23:16], s[1] ? n[15:8] : o[15:8], s[0] ? n[7:0] : o[7:0]};
    endfunction

    function automatic logic is_mapped(input logic [13:0] idx);
        return idx == 14'h0000 || idx == 14'h1000 || idx == 14'h1001 || idx == 14'h2FFE || idx == 14'h2FFF;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [13:0] idx, input logic [63:0] c);
        logic [63:0] mt;
        mt = c + m_off;
        return idx == 14'h0000 ? {31'b0, m_msip} : idx == 14'h1000 ? m_cmp[31:0] : idx == 14'h1001 ? m_cmp[63:32] :
               idx == 14'h2FFE ? mt[31:0] : idx == 14'h2FFF ? mt[63:32] : 32'h0;
    endfunction

    function automatic logic sig(input int w);
        return w == 0 ? bus.awready : w == 1 ? bus.wready : w == 2 ? bus.bvalid : w == 3 ? bus.arready : bus.rvalid;
    endfunction

    task automatic wait_hi(input string tag, input int w, output logic [63:0] c);
        int n = 0;
        @(negedge clk);
        while (!sig(w) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!sig(w)) check({tag, "_timeout"}, 64'(sig(w)), 64'd1);
        c = cyc;
    endtask

    task automatic do_reset();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        m_off = '0; m_cmp = '1; m_msip = 0;
        rq.delete(); bq.delete();
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int a_dly, input int w_dly, output logic [63:0] we);
        logic [63:0] ta, tw, cur, nv, c;
        logic [13:0] idx;
        logic [1:0] e;
        idx = a[15:2];
        bq.push_back(is_mapped(idx) ? 2'b00 : 2'b10);
        fork
            begin
                if (a_dly > 0) begin repeat (a_dly) @(posedge clk); #1; end
                bus.awaddr = a; bus.awvalid = 1;
                wait_hi("aw", 0, ta);
                @(posedge clk); #1 bus.awvalid = 0;
            end
            begin
                if (w_dly > 0) begin repeat (w_dly) @(posedge clk); #1; end
                bus.wdata = d; bus.wstrb = s; bus.wvalid = 1;
                wait_hi("w", 1, tw);
                @(posedge clk); #1 bus.wvalid = 0;
            end
        join
        we = ta > tw ? ta : tw;
        cur = we + m_off;
        if (idx == 14'h0000 && s[0]) m_msip = d[0];
        if (idx == 14'h1000) m_cmp[31:0] = mrg(m_cmp[31:0], d, s);
        if (idx == 14'h1001) m_cmp[63:32] = mrg(m_cmp[63:32], d, s);
        if (idx == 14'h2FFE || idx == 14'h2FFF) begin
            nv = idx == 14'h2FFE ? {cur[63:32], mrg(cur[31:0], d, s)} : {mrg(cur[63:32], d, s), cur[31:0]};
            m_off = nv - (we + 64'd1);
        end
        wait_hi("b", 2, c);
        if (bq.size() == 0) check("bq_empty", 64'(bq.size()), 64'd1);
        else begin
            e = bq.pop_front();
            check("bresp", bus.bresp, e);
        end
        bus.bready = 1;
        @(posedge clk); #1 bus.bready = 0;
    endtask

    task automatic axi_rd(input logic [31:0] a, input int hold, output logic [31:0] got);
        logic [63:0] c;
        rexp_t e;
        bus.araddr = a; bus.arvalid = 1;
        wait_hi("ar", 3, c);
        e.d = exp_rd(a[15:2], c);
        e.r = is_mapped(a[15:2]) ? 2'b00 : 2'b10;
        rq.push_back(e);
        @(posedge clk); #1 bus.arvalid = 0;
        wait_hi("r", 4, c);
        repeat (hold) @(negedge clk);
        if (hold > 0) check("rvalid_held", bus.rvalid, 1);
        if (rq.size() == 0) check("rq_empty", 64'(rq.size()), 64'd1);
        else begin
            e = rq.pop_front();
            check("rdata", bus.rdata, e.d);
            check("rresp", bus.rresp, e.r);
        end
        got = bus.rdata;
        bus.rready = 1;
        @(posedge clk); #1 bus.rready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] we;
        logic [31:0] v;
        int n;
        bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0; bus.araddr = 0;
        do_reset();
        check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
        check("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
        check("rst_rdata", bus.rdata, 0);
        check("rst_irq", {timer_irq, soft_irq}, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        axi_rd(32'h0000_BFF8, 0, v);
        check("idle_mtime_range", 64'(v >= 10 && v <= 12), 1);
        axi_rd(32'h0000_4004, 0, v);
        check("idle_timer_irq", timer_irq, 0);

        do_reset();
        axi_wr(32'h4000, 32'd20, 4'hF, 2, 0, we);
        axi_wr(32'h4004, 32'd0, 4'hF, 0, 0, we);
        n = 0;
        while (!timer_irq && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("irq_rise_cycle", cyc, 21);
        @(posedge clk); #1;
        axi_wr(32'h4004, 32'd1, 4'hF, 0, 0, we);
        @(negedge clk); #1;
        check("irq_before_fall", irq_at[10'(we + 1)], 1);
        check("irq_fall", irq_at[10'(we + 2)], 0);
        @(posedge clk); #1;

        axi_wr(32'h0000, 32'hFFFF_FFFF, 4'b0001, 0, 0, we);
        @(negedge clk); #1;
        check("soft_before", soft_at[10'(we + 1)], 0);
        check("soft_rise", soft_at[10'(we + 2)], 1);
        @(posedge clk); #1;
        axi_rd(32'h0000, 0, v);
        axi_wr(32'h0000, 32'h0, 4'b0000, 1, 0, we);
        @(negedge clk); #1;
        check("soft_strb0", soft_at[10'(we + 2)], 1);
        @(posedge clk); #1;
        axi_rd(32'h0000, 0, v);

        axi_wr(32'hBFFC, 32'h0, 4'hF, 0, 1, we);
        axi_wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0, we);
        axi_rd(32'hBFFC, 0, v);
        check("carry_hi", v, 1);
        axi_rd(32'hBFF8, 0, v);

        axi_wr(32'h1234, 32'h55, 4'hF, 0, 0, we);
        axi_rd(32'h1234, 0, v);
        axi_rd(32'h4000, 0, v);
        axi_wr(32'h4000, 32'hAABB_CCDD, 4'b0101, 0, 0, we);
        axi_rd(32'h4000, 0, v);
        check("strb_merge", v, 32'h00BB_00DD);
        axi_rd(32'h4004, 5, v);

        bus.awaddr = 32'h0; bus.awvalid = 1; bus.wdata = 32'h1; bus.wstrb = 4'h1; bus.wvalid = 1;
        wait_hi("aw_rst", 0, we);
        @(posedge clk); #1 bus.awvalid = 0; bus.wvalid = 0;
        wait_hi("b_rst", 2, we);
        rst = 1;
        @(posedge clk); #1;
        check("rst_bvalid_drop", bus.bvalid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_off = '0; m_cmp = '1; m_msip = 0;
        rq.delete(); bq.delete();
        check("rst2_ready", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
        check("rst2_irq", {timer_irq, soft_irq}, 2'b00);
        axi_rd(32'h0000, 0, v);
        axi_rd(32'h4000, 0, v);
        axi_rd(32'h4004, 0, v);
        axi_rd(32'hBFF8, 0, v);
        axi_rd(32'hBFFC, 0, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
